// File: rtl/axi_w_aw_gate.sv
// axi_w_aw_gate: hold W beats until their AW length is queued, regenerate WLAST, flag WLAST mismatches
module axi_w_aw_gate #(
    parameter int DATA_WIDTH = 64,
    parameter int USER_WIDTH = 6,
    parameter int LEN_DEPTH = 4,
    localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        aw_valid_i,
    input  logic [7:0]                  aw_len_i,
    output logic                        aw_ready_o,
    input  logic                        slave_valid_i,
    input  logic [DATA_WIDTH-1:0]       slave_data_i,
    input  logic [STRB_WIDTH-1:0]       slave_strb_i,
    input  logic [USER_WIDTH-1:0]       slave_user_i,
    input  logic                        slave_last_i,
    output logic                        slave_ready_o,
    output logic                        master_valid_o,
    output logic [DATA_WIDTH-1:0]       master_data_o,
    output logic [STRB_WIDTH-1:0]       master_strb_o,
    output logic [USER_WIDTH-1:0]       master_user_o,
    output logic                        master_last_o,
    input  logic                        master_ready_i,
    output logic                        last_err_o,
    output logic [$clog2(LEN_DEPTH+1)-1:0] pending_o
);
    localparam int PW = $clog2(LEN_DEPTH);
    localparam int CW = $clog2(LEN_DEPTH + 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t        state;
    logic [7:0]    mem [LEN_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [7:0]    beat_cnt;
    logic          full, active, push, beat, pop;

    assign full           = count == CW'(LEN_DEPTH);
    assign active         = state == BURST && !rst_i;
    assign aw_ready_o     = !full && !rst_i;
    assign push           = aw_valid_i && aw_ready_o;
    assign master_valid_o = slave_valid_i && active;
    assign slave_ready_o  = master_ready_i && active;
    assign master_data_o  = slave_data_i;
    assign master_strb_o  = slave_strb_i;
    assign master_user_o  = slave_user_i;
    assign master_last_o  = active && beat_cnt == mem[rd_ptr];
    assign beat           = master_valid_o && master_ready_i;
    assign pop            = beat && master_last_o;
    assign pending_o      = count;

    // length storage; contents are don't-care while the queue is empty
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= aw_len_i;
    end

    // queue pointers, beat counter, error pulse and IDLE/BURST state
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            beat_cnt   <= '0;
            last_err_o <= 1'b0;
        end else begin
            wr_ptr     <= push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr     <= pop ? rd_ptr + 1'b1 : rd_ptr;
            count      <= count + CW'(push) - CW'(pop);
            beat_cnt   <= pop ? 8'd0 : beat ? beat_cnt + 8'd1 : beat_cnt;
            last_err_o <= beat && (slave_last_i != master_last_o);
            state      <= state == IDLE ? (push ? BURST : IDLE)
                        : (pop && count == CW'(1) && !push) ? IDLE : BURST;
        end
    end
endmodule

// File: tb/tb_axi_w_aw_gate.sv
// tb_axi_w_aw_gate: randomized scoreboard bench with an abstract length-queue reference model
module tb_axi_w_aw_gate;
    localparam int DEPTH = 4;

    typedef struct {
        logic [63:0] d;
        logic [7:0]  s;
        logic [5:0]  u;
        logic        l;
        logic        sl;
    } beat_t;

    logic        clk = 0;
    logic        rst_i = 1;
    logic        aw_valid_i = 0;
    logic [7:0]  aw_len_i = 0;
    logic        aw_ready_o;
    logic        slave_valid_i = 0;
    logic [63:0] slave_data_i = 0;
    logic [7:0]  slave_strb_i = 0;
    logic [5:0]  slave_user_i = 0;
    logic        slave_last_i = 0;
    logic        slave_ready_o;
    logic        master_valid_o;
    logic [63:0] master_data_o;
    logic [7:0]  master_strb_o;
    logic [5:0]  master_user_o;
    logic        master_last_o;
    logic        master_ready_i = 0;
    logic        last_err_o;
    logic [2:0]  pending_o;

    axi_w_aw_gate #(.DATA_WIDTH(64), .USER_WIDTH(6), .LEN_DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .aw_valid_i(aw_valid_i), .aw_len_i(aw_len_i), .aw_ready_o(aw_ready_o),
        .slave_valid_i(slave_valid_i), .slave_data_i(slave_data_i), .slave_strb_i(slave_strb_i),
        .slave_user_i(slave_user_i), .slave_last_i(slave_last_i), .slave_ready_o(slave_ready_o),
        .master_valid_o(master_valid_o), .master_data_o(master_data_o), .master_strb_o(master_strb_o),
        .master_user_o(master_user_o), .master_last_o(master_last_o), .master_ready_i(master_ready_i),
        .last_err_o(last_err_o), .pending_o(pending_o)
    );

    always #5 clk = ~clk;

    int vec = 0;
    int miss = 0;
    int p_aw = 100, p_w = 100, p_rdy = 100;

    logic [7:0] aw_q[$];
    beat_t      w_q[$];
    beat_t      exp_q[$];

    logic [7:0] lq[$];
    int         bi = 0;
    logic       err_exp = 0;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        vec++;
        if (a !== e) begin
            miss++;
            $display("FAIL %s at %0t: got %0h expected %0h", n, $time, a, e);
        end
    endtask

    task automatic gen(input int len, input int bad);
        beat_t b;
        aw_q.push_back(8'(len));
        for (int i = 0; i <= len; i++) begin
            b.d  = {$urandom, $urandom};
            b.s  = 8'($urandom);
            b.u  = 6'($urandom);
            b.l  = (i == len);
            b.sl = b.l ^ (i == bad || (bad == -2 && $urandom_range(0, 9) == 0));
            w_q.push_back(b);
            exp_q.push_back(b);
        end
    endtask

    task automatic step();
        logic awt, wt;
        @(negedge clk);
        awt = aw_valid_i && aw_ready_o;
        wt  = slave_valid_i && slave_ready_o;
        @(posedge clk);
        #1;
        if (awt && aw_q.size() > 0) void'(aw_q.pop_front());
        if (wt && w_q.size() > 0) void'(w_q.pop_front());
        aw_valid_i     = aw_q.size() > 0 && $urandom_range(0, 99) < p_aw;
        aw_len_i       = aw_q.size() > 0 ? aw_q[0] : 8'(0);
        slave_valid_i  = w_q.size() > 0 && $urandom_range(0, 99) < p_w;
        slave_data_i   = w_q.size() > 0 ? w_q[0].d : 64'(0);
        slave_strb_i   = w_q.size() > 0 ? w_q[0].s : 8'(0);
        slave_user_i   = w_q.size() > 0 ? w_q[0].u : 6'(0);
        slave_last_i   = w_q.size() > 0 ? w_q[0].sl : 1'b0;
        master_ready_i = $urandom_range(0, 99) < p_rdy;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() > 0 || aw_q.size() > 0) && n < 20000) begin
            step();
            n++;
        end
        if (n >= 20000) begin
            miss++;
            $display("FAIL drain timeout: %0d beats outstanding, expected 0", exp_q.size());
        end
        repeat (2) step();
    endtask

    // monitor: compare DUT against the abstract model, then advance the model by one clock
    initial begin
        beat_t e;
        logic act, lst, hs, awhs;
        forever begin
            @(negedge clk);
            act = !rst_i && lq.size() > 0;
            lst = act && bi == int'(lq[0]);
            chk("aw_ready", aw_ready_o, !rst_i && lq.size() < DEPTH);
            chk("master_valid", master_valid_o, slave_valid_i && act);
            chk("slave_ready", slave_ready_o, master_ready_i && act);
            chk("master_last", master_last_o, lst);
            chk("pending", pending_o, lq.size());
            chk("last_err", last_err_o, err_exp);
            if (rst_i) begin
                lq.delete();
                bi = 0;
                err_exp = 0;
            end else begin
                hs   = slave_valid_i && master_ready_i && act;
                awhs = aw_valid_i && lq.size() < DEPTH;
                err_exp = 0;
                if (hs) begin
                    if (exp_q.size() == 0) begin
                        miss++;
                        $display("FAIL unexpected_beat: got data %0h expected no beat", master_data_o);
                    end else begin
                        e = exp_q.pop_front();
                        chk("data", master_data_o, e.d);
                        chk("strb", master_strb_o, e.s);
                        chk("user", master_user_o, e.u);
                        chk("beat_last", master_last_o, e.l);
                        err_exp = slave_last_i != e.l;
                    end
                    if (lst) begin
                        void'(lq.pop_front());
                        bi = 0;
                    end else bi++;
                end
                if (awhs) lq.push_back(aw_len_i);
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1 rst_i = 0;
        step();
        gen(3, -1);
        drain();
        p_aw = 0;
        gen(0, -1);
        repeat (3) step();
        p_aw = 100;
        drain();
        p_w = 0;
        gen(0, -1); gen(1, -1); gen(2, -1); gen(7, -1);
        repeat (6) step();
        p_w = 100;
        drain();
        gen(2, 1);
        drain();
        p_rdy = 50;
        gen(255, -1);
        drain();
        p_rdy = 100;
        gen(5, -1);
        n = 0;
        while (exp_q.size() > 4 && n < 50) begin
            step();
            n++;
        end
        rst_i = 1;
        aw_q.delete();
        exp_q.delete();
        aw_valid_i = 0;
        repeat (2) step();
        rst_i = 0;
        repeat (6) step();
        w_q.delete();
        step();
        for (int k = 0; k < 40; k++) begin
            p_aw  = $urandom_range(20, 100);
            p_w   = $urandom_range(30, 100);
            p_rdy = $urandom_range(30, 100);
            gen($urandom_range(0, 3) == 0 ? 0 : $urandom_range(0, 12), -2);
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 6)) step();
        end
        drain();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule

// File: doc/axi_w_aw_gate.md
# axi_w_aw_gate

AXI4 write-data gate sitting directly upstream of the W-channel buffer in the master slice. It holds W beats back until the matching AW burst length has been accepted, so no write data reaches the buffer ahead of its address. It forwards beats in AW order and regenerates WLAST from the stored burst length. A mismatch with the incoming WLAST is flagged, not propagated.

## Interface
Parameters:
- DATA_WIDTH, 64, W data width in bits
- USER_WIDTH, 6, W user width in bits
- LEN_DEPTH, 4, number of AW lengths that can be queued (power of two, ≥2)
- STRB_WIDTH, DATA_WIDTH/8, strobe width; derived, not overridden

Ports:
- clk_i  in  1  clock; everything is sampled on its rising edge
- rst_i  in  1  reset, synchronous, active-high
- aw_valid_i  in  1  AW handshake valid (tap of the AW channel)
- aw_len_i  in  8  AWLEN of the burst (beats − 1)
- aw_ready_o  out  1  length queue can accept
- slave_valid_i  in  1  upstream W valid
- slave_data_i  in  DATA_WIDTH  upstream W data
- slave_strb_i  in  STRB_WIDTH  upstream W strobe
- slave_user_i  in  USER_WIDTH  upstream W user
- slave_last_i  in  1  upstream WLAST (checked only)
- slave_ready_o  out  1  upstream W ready
- master_valid_o  out  1  W valid toward the W buffer
- master_data_o  out  DATA_WIDTH  passthrough of slave_data_i
- master_strb_o  out  STRB_WIDTH  passthrough of slave_strb_i
- master_user_o  out  USER_WIDTH  passthrough of slave_user_i
- master_last_o  out  1  regenerated WLAST
- master_ready_i  in  1  W buffer ready
- last_err_o  out  1  one-cycle pulse on a WLAST mismatch
- pending_o  out  $clog2(LEN_DEPTH+1)  number of queued AW lengths, including the burst in progress

## Operation
Length queue:
- Circular FIFO of LEN_DEPTH 8-bit entries, with write pointer, read pointer and count.
- Push when aw_valid_i && aw_ready_o.
- aw_ready_o = !full && !rst_i. There is no bypass when full, even if a pop happens in the same cycle.
- Pointers wrap modulo LEN_DEPTH.

Beat counter:
- beat_cnt is 8 bits and counts accepted beats of the head burst.

W path (combinational, zero latency):
- master_valid_o = slave_valid_i && !empty.
- slave_ready_o = master_ready_i && !empty.
- Data, strobe and user pass straight through.
- master_last_o = !empty && (beat_cnt == head_len).

On a beat handshake (master_valid_o && master_ready_i):
- If master_last_o: pop the queue and set beat_cnt ← 0.
- Otherwise: beat_cnt ← beat_cnt + 1.

Simultaneous push and pop (not full): count unchanged, both pointers advance.

Error check:
- On every beat handshake, if slave_last_i != master_last_o, then last_err_o = 1 in the next cycle, for one cycle only.
- The error pulse does not alter forwarding. The burst length is always taken from AW.

State machine:
- IDLE (queue empty): W is blocked.
- BURST (queue non-empty): beats pass.
- BURST → IDLE on a last beat when count = 1 and there is no push that cycle.
- IDLE → BURST on any push.

pending_o = count.

## Timing
Reset (rst_i high at a clock edge):
- Queue empties, pointers = 0, beat_cnt = 0, last_err_o = 0, pending_o = 0.
- While rst_i is high: aw_ready_o = 0, slave_ready_o = 0, master_valid_o = 0, master_last_o = 0.
- Reset mid-burst discards all queued lengths and the partial beat count. Beats from the aborted burst are not forwarded after reset until a new AW push arrives.

Latency:
- AW push at edge N → first W beat can be forwarded in cycle N+1 (no same-cycle bypass).
- W beats have zero cycles of latency.
- last_err_o asserts exactly one cycle after the offending beat.

Handshakes and boundaries:
- master_valid_o never depends on master_ready_i.
- The only dependency of slave_ready_o on master_ready_i is combinational.
- Full queue: aw_ready_o = 0 until a pop registers.
- AWLEN = 0: every beat is a last beat and pops immediately.
- AWLEN = 255: beat_cnt reaches 255 without overflow and then resets to 0.
- Back-to-back bursts: the beat after a last beat belongs to the next head burst in the same throughput, with no bubble.

## Test plan
- Reset, then one AW with len=3 followed by 4 W beats at full rate → exactly 4 beats forwarded, master_last_o high only on beat 4, pending_o goes 1→0, last_err_o stays 0.
- W beats arrive before any AW → master_valid_o = 0 and slave_ready_o = 0. Push AW len=0 at edge N → the beat passes in cycle N+1 with last = 1.
- Push 4 AWs (len 0,1,2,7) with no W traffic → aw_ready_o drops after the 4th and pending_o = 4. Stream 14 beats → lasts appear on beats 1, 3, 6 and 14, and aw_ready_o returns the cycle after the first pop.
- AW len=2, with upstream asserting slave_last_i on beat 2 → last_err_o pulses in the cycle after beat 2, and beat 3 is still forwarded with master_last_o = 1.
- master_ready_i toggled randomly during a len=255 burst → 256 beats forwarded, last only on the 256th, beat_cnt wraps to 0.
- Assert rst_i mid-burst (after beat 2 of len=5) → all outputs take their reset values, pending_o = 0, and subsequent W beats stay blocked until a new AW arrives.
